// File: rtl/cache_line_state_array.sv
// Per-line Valid/Dirty/PTC store for a SETS x WAYS cache: one line op per cycle, victim selection,
// single-outstanding writeback handshake. Define CACHE_LINE_STATE_PLRU_EN for tree pseudo-LRU replacement.
module cache_line_state_array #(
    parameter int WAY_W = 2,
    parameter int SET_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [2:0]              op_code,
    input  logic [SET_W-1:0]        op_set,
    input  logic [WAY_W-1:0]        op_way,
    input  logic                    op_use_victim,
    output logic [(2**WAY_W)-1:0]   rd_v,
    output logic [(2**WAY_W)-1:0]   rd_d,
    output logic [(2**WAY_W)-1:0]   rd_ptc,
    output logic [WAY_W-1:0]        victim_way,
    output logic                    wb_req,
    output logic [SET_W-1:0]        wb_set,
    output logic [WAY_W-1:0]        wb_way,
    input  logic                    wb_ack,
    output logic                    op_err
);
    localparam int WAYS = 2 ** WAY_W;
    localparam int SETS = 2 ** SET_W;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_ALLOC   = 3'd1;
    localparam logic [2:0] OP_FILL    = 3'd2;
    localparam logic [2:0] OP_STORE   = 3'd3;
    localparam logic [2:0] OP_EXTRACT = 3'd4;
    localparam logic [2:0] OP_CLEAN   = 3'd5;
    localparam logic [2:0] OP_INVAL   = 3'd6;

`ifdef CACHE_LINE_STATE_PLRU_EN
    localparam int REPL_W = WAYS - 1;

    // Tree bits are heap-ordered (children of node n at 2n+1, 2n+2); a 1 points to the upper half.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [REPL_W-1:0] t);
        logic [WAY_W-1:0] w;
        int n;
        w = '0;
        n = 0;
        for (int l = 0; l < WAY_W; l++) begin
            w[WAY_W-1-l] = t[n];
            n = 2 * n + 1 + int'(t[n]);
        end
        return w;
    endfunction

    function automatic logic [REPL_W-1:0] plru_touch(input logic [REPL_W-1:0] t,
                                                     input logic [WAY_W-1:0] w);
        logic [REPL_W-1:0] r;
        int n;
        r = t;
        n = 0;
        for (int l = 0; l < WAY_W; l++) begin
            r[n] = ~w[WAY_W-1-l];
            n = 2 * n + 1 + int'(w[WAY_W-1-l]);
        end
        return r;
    endfunction
`else
    localparam int REPL_W = WAY_W;
`endif

    typedef enum logic {S_IDLE, S_WB} wb_state_e;

    logic [SETS-1:0][WAYS-1:0]   v_q, v_d, d_q, d_d, ptc_q, ptc_d;
    logic [SETS-1:0][REPL_W-1:0] repl_q, repl_d;
    wb_state_e                   state_q, state_d;
    logic [SET_W-1:0]            wb_set_q, wb_set_d;
    logic [WAY_W-1:0]            wb_way_q, wb_way_d;
    logic                        wb_ext_q, wb_ext_d;
    logic                        op_err_q, op_err_d;

    logic [WAY_W-1:0] repl_choice;
    logic [WAY_W-1:0] cand;
    logic             found;
    logic [WAY_W-1:0] tgt_way;
    logic             cur_v, cur_d, cur_ptc;
    logic             touch;

    assign rd_v     = v_q[op_set];
    assign rd_d     = d_q[op_set];
    assign rd_ptc   = ptc_q[op_set];
    assign op_ready = (state_q == S_IDLE);
    assign wb_req   = (state_q == S_WB);
    assign wb_set   = wb_set_q;
    assign wb_way   = wb_way_q;
    assign op_err   = op_err_q;

`ifdef CACHE_LINE_STATE_PLRU_EN
    assign repl_choice = plru_victim(repl_q[op_set]);
`else
    assign repl_choice = repl_q[op_set];
`endif

    // Free way first; otherwise the replacement pick, stepping upward past lines still filling.
    always_comb begin
        victim_way = '0;
        found      = 1'b0;
        cand       = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !v_q[op_set][w] && !ptc_q[op_set][w]) begin
                victim_way = WAY_W'(w);
                found      = 1'b1;
            end
        end
        for (int k = 0; k < WAYS; k++) begin
            cand = repl_choice + WAY_W'(k);
            if (!found && !ptc_q[op_set][cand]) begin
                victim_way = cand;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        v_d      = v_q;
        d_d      = d_q;
        ptc_d    = ptc_q;
        repl_d   = repl_q;
        state_d  = state_q;
        wb_set_d = wb_set_q;
        wb_way_d = wb_way_q;
        wb_ext_d = wb_ext_q;
        op_err_d = 1'b0;
        touch    = 1'b0;
        tgt_way  = (op_code == OP_ALLOC && op_use_victim) ? victim_way : op_way;
        cur_v    = v_q[op_set][tgt_way];
        cur_d    = d_q[op_set][tgt_way];
        cur_ptc  = ptc_q[op_set][tgt_way];

        if (state_q == S_WB) begin
            if (wb_ack) begin
                d_d[wb_set_q][wb_way_q] = 1'b0;
                if (wb_ext_q) begin
                    v_d[wb_set_q][wb_way_q]   = 1'b0;
                    ptc_d[wb_set_q][wb_way_q] = 1'b0;
                end
                state_d = S_IDLE;
            end
        end else if (op_valid) begin
            case (op_code)
                OP_NOP: ;
                OP_ALLOC: begin
                    if (cur_v && cur_d) begin
                        op_err_d = 1'b1;
                    end else begin
                        ptc_d[op_set][tgt_way] = 1'b1;
                        v_d[op_set][tgt_way]   = 1'b0;
                        d_d[op_set][tgt_way]   = 1'b0;
                        touch                  = 1'b1;
                    end
                end
                OP_FILL: begin
                    if (cur_ptc) begin
                        ptc_d[op_set][tgt_way] = 1'b0;
                        v_d[op_set][tgt_way]   = 1'b1;
                        touch                  = 1'b1;
                    end else begin
                        op_err_d = 1'b1;
                    end
                end
                OP_STORE: begin
                    if (cur_v && !cur_ptc) begin
                        d_d[op_set][tgt_way] = 1'b1;
                        touch                = 1'b1;
                    end else begin
                        op_err_d = 1'b1;
                    end
                end
                OP_EXTRACT, OP_CLEAN: begin
                    if (cur_v && cur_d) begin
                        state_d  = S_WB;
                        wb_set_d = op_set;
                        wb_way_d = tgt_way;
                        wb_ext_d = (op_code == OP_EXTRACT);
                    end else if (cur_v && op_code == OP_EXTRACT) begin
                        v_d[op_set][tgt_way]   = 1'b0;
                        d_d[op_set][tgt_way]   = 1'b0;
                        ptc_d[op_set][tgt_way] = 1'b0;
                    end
                end
                OP_INVAL: begin
                    v_d[op_set][tgt_way]   = 1'b0;
                    d_d[op_set][tgt_way]   = 1'b0;
                    ptc_d[op_set][tgt_way] = 1'b0;
                end
                default: op_err_d = 1'b1;
            endcase
        end

`ifdef CACHE_LINE_STATE_PLRU_EN
        if (touch) repl_d[op_set] = plru_touch(repl_q[op_set], tgt_way);
`else
        if (touch && op_code == OP_ALLOC && op_use_victim) repl_d[op_set] = repl_q[op_set] + REPL_W'(1);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q      <= '0;
            d_q      <= '0;
            ptc_q    <= '0;
            repl_q   <= '0;
            state_q  <= S_IDLE;
            wb_set_q <= '0;
            wb_way_q <= '0;
            wb_ext_q <= 1'b0;
            op_err_q <= 1'b0;
        end else begin
            v_q      <= v_d;
            d_q      <= d_d;
            ptc_q    <= ptc_d;
            repl_q   <= repl_d;
            state_q  <= state_d;
            wb_set_q <= wb_set_d;
            wb_way_q <= wb_way_d;
            wb_ext_q <= wb_ext_d;
            op_err_q <= op_err_d;
        end
    end
endmodule

// File: tb/tb_cache_line_state_array.sv
// Directed bench for cache_line_state_array: line ops, victim selection, writeback handshake, reset.
module tb_cache_line_state_array;
    localparam int WAY_W = 2;
    localparam int SET_W = 4;

    localparam logic [2:0] NOP = 3'd0, ALLOC = 3'd1, FILL = 3'd2, STORE = 3'd3;
    localparam logic [2:0] EXTRACT = 3'd4, CLEAN = 3'd5, INVAL = 3'd6, RSVD = 3'd7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [2:0]       op_code = 3'd0;
    logic [SET_W-1:0] op_set = '0;
    logic [WAY_W-1:0] op_way = '0;
    logic             op_use_victim = 1'b0;
    logic [3:0]       rd_v, rd_d, rd_ptc;
    logic [WAY_W-1:0] victim_way;
    logic             wb_req;
    logic [SET_W-1:0] wb_set;
    logic [WAY_W-1:0] wb_way;
    logic             wb_ack = 1'b0;
    logic             op_err;

    int total = 0;
    int bad   = 0;

    cache_line_state_array #(.WAY_W(WAY_W), .SET_W(SET_W)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_set(op_set), .op_way(op_way), .op_use_victim(op_use_victim),
        .rd_v(rd_v), .rd_d(rd_d), .rd_ptc(rd_ptc), .victim_way(victim_way),
        .wb_req(wb_req), .wb_set(wb_set), .wb_way(wb_way), .wb_ack(wb_ack), .op_err(op_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [2:0] c, input logic [3:0] s, input logic [1:0] w, input logic vic);
        op_valid      = 1'b1;
        op_code       = c;
        op_set        = s;
        op_way        = w;
        op_use_victim = vic;
        step();
        op_valid      = 1'b0;
        op_use_victim = 1'b0;
    endtask

    initial begin
        logic [1:0] exp_vic [5];
        exp_vic = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // Reset and idle view of set 3
        rst = 1'b1;
        step();
        step();
        rst    = 1'b0;
        op_set = 4'd3;
        step();
        check("rst_rd_v", rd_v, 4'b0000);
        check("rst_rd_d", rd_d, 4'b0000);
        check("rst_rd_ptc", rd_ptc, 4'b0000);
        check("rst_victim", victim_way, 2'd0);
        check("rst_ready", op_ready, 1'b1);
        check("rst_wb_req", wb_req, 1'b0);
        check("rst_op_err", op_err, 1'b0);

        // Allocate, fill and dirty s5/w2
        do_op(ALLOC, 4'd5, 2'd2, 1'b0);
        check("alloc_ptc", rd_ptc, 4'b0100);
        check("alloc_v", rd_v, 4'b0000);
        do_op(FILL, 4'd5, 2'd2, 1'b0);
        check("fill_v", rd_v, 4'b0100);
        check("fill_ptc", rd_ptc, 4'b0000);
        do_op(STORE, 4'd5, 2'd2, 1'b0);
        check("store_d", rd_d, 4'b0100);
        check("store_v", rd_v, 4'b0100);
        check("store_err", op_err, 1'b0);
        do_op(STORE, 4'd5, 2'd1, 1'b0);
        check("store_inv_err", op_err, 1'b1);
        check("store_inv_v", rd_v, 4'b0100);
        check("store_inv_d", rd_d, 4'b0100);
        step();
        check("err_one_cycle", op_err, 1'b0);

        // Dirty EXTRACT with a delayed ack; an op offered meanwhile must be held off
        do_op(EXTRACT, 4'd5, 2'd2, 1'b0);
        check("ext_wb_req", wb_req, 1'b1);
        check("ext_wb_set", wb_set, 4'd5);
        check("ext_wb_way", wb_way, 2'd2);
        check("ext_ready", op_ready, 1'b0);
        op_valid = 1'b1;
        op_code  = INVAL;
        for (int i = 0; i < 4; i++) begin
            step();
            check("ext_hold_req", wb_req, 1'b1);
            check("ext_hold_v", rd_v, 4'b0100);
        end
        op_valid = 1'b0;
        wb_ack   = 1'b1;
        step();
        wb_ack = 1'b0;
        check("ext_ack_v", rd_v, 4'b0000);
        check("ext_ack_d", rd_d, 4'b0000);
        check("ext_ack_req", wb_req, 1'b0);
        check("ext_ack_ready", op_ready, 1'b1);

        // Fill all ways of set 0, then touch w0..w3
        for (int w = 0; w < 4; w++) begin
            do_op(ALLOC, 4'd0, 2'(w), 1'b0);
            do_op(FILL, 4'd0, 2'(w), 1'b0);
        end
        for (int w = 0; w < 4; w++) do_op(STORE, 4'd0, 2'(w), 1'b0);
        check("s0_all_v", rd_v, 4'b1111);
        check("s0_victim", victim_way, 2'd0);
        do_op(STORE, 4'd0, 2'd0, 1'b0);
`ifdef CACHE_LINE_STATE_PLRU_EN
        check("s0_victim_after_w0", victim_way, 2'd2);
`else
        check("s0_victim_after_w0", victim_way, 2'd0);

        // Round-robin victims in set 1 (op_way deliberately wrong to show it is overridden)
        for (int w = 0; w < 4; w++) begin
            do_op(ALLOC, 4'd1, 2'(w), 1'b0);
            do_op(FILL, 4'd1, 2'(w), 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            op_set = 4'd1;
            #1;
            check("rr_victim", victim_way, exp_vic[i]);
            do_op(ALLOC, 4'd1, 2'd3, 1'b1);
            check("rr_alloc_err", op_err, 1'b0);
        end
        check("rr_ptc_all", rd_ptc, 4'b1111);
        check("rr_v_none", rd_v, 4'b0000);
`endif

        // Reset in the middle of a writeback
        do_op(ALLOC, 4'd6, 2'd1, 1'b0);
        do_op(FILL, 4'd6, 2'd1, 1'b0);
        do_op(STORE, 4'd6, 2'd1, 1'b0);
        do_op(EXTRACT, 4'd6, 2'd1, 1'b0);
        check("mid_wb_req", wb_req, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_req", wb_req, 1'b0);
        check("mid_rst_ready", op_ready, 1'b1);
        check("mid_rst_v6", rd_v, 4'b0000);
        check("mid_rst_d6", rd_d, 4'b0000);
        op_set = 4'd0;
        #1;
        check("mid_rst_v0", rd_v, 4'b0000);
        check("mid_rst_d0", rd_d, 4'b0000);
        op_set = 4'd6;
        step();
        rst    = 1'b0;
        wb_ack = 1'b1;
        step();
        wb_ack = 1'b0;
        check("post_rst_req", wb_req, 1'b0);
        check("post_rst_ready", op_ready, 1'b1);
        check("post_rst_v", rd_v, 4'b0000);
        check("post_rst_err", op_err, 1'b0);

        // CLEAN with immediate ack keeps V
        do_op(ALLOC, 4'd7, 2'd3, 1'b0);
        do_op(FILL, 4'd7, 2'd3, 1'b0);
        do_op(STORE, 4'd7, 2'd3, 1'b0);
        do_op(CLEAN, 4'd7, 2'd3, 1'b0);
        check("clean_req", wb_req, 1'b1);
        check("clean_set", wb_set, 4'd7);
        check("clean_way", wb_way, 2'd3);
        wb_ack = 1'b1;
        step();
        wb_ack = 1'b0;
        check("clean_v", rd_v, 4'b1000);
        check("clean_d", rd_d, 4'b0000);
        check("clean_ready", op_ready, 1'b1);
        do_op(CLEAN, 4'd7, 2'd3, 1'b0);
        check("clean_clean_req", wb_req, 1'b0);
        check("clean_clean_err", op_err, 1'b0);
        do_op(FILL, 4'd7, 2'd3, 1'b0);
        check("fill_noptc_err", op_err, 1'b1);
        check("fill_noptc_v", rd_v, 4'b1000);

        // ALLOC on a dirty line is refused; INVAL discards it
        do_op(STORE, 4'd7, 2'd3, 1'b0);
        do_op(ALLOC, 4'd7, 2'd3, 1'b0);
        check("alloc_dirty_err", op_err, 1'b1);
        check("alloc_dirty_d", rd_d, 4'b1000);
        check("alloc_dirty_ptc", rd_ptc, 4'b0000);
        do_op(INVAL, 4'd7, 2'd3, 1'b0);
        check("inval_v", rd_v, 4'b0000);
        check("inval_d", rd_d, 4'b0000);
        check("inval_req", wb_req, 1'b0);
        do_op(EXTRACT, 4'd7, 2'd3, 1'b0);
        check("ext_invalid_err", op_err, 1'b0);
        check("ext_invalid_req", wb_req, 1'b0);

        // Clean EXTRACT drops the line at once; reserved op flags an error
        do_op(ALLOC, 4'd7, 2'd0, 1'b0);
        do_op(FILL, 4'd7, 2'd0, 1'b0);
        check("ext_clean_pre_v", rd_v, 4'b0001);
        do_op(EXTRACT, 4'd7, 2'd0, 1'b0);
        check("ext_clean_v", rd_v, 4'b0000);
        check("ext_clean_req", wb_req, 1'b0);
        do_op(RSVD, 4'd7, 2'd0, 1'b0);
        check("rsvd_err", op_err, 1'b1);
        do_op(NOP, 4'd7, 2'd0, 1'b0);
        check("nop_err", op_err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
